// File: rtl/decode_queue.sv
// decode_queue: RV32I fetch-to-execute instruction buffer with a registered decode stage.
// A DEPTH-entry circular buffer feeds one output register that holds fully decoded control.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_instr,
    input  logic [XLEN-1:0]         in_pc,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic                    MemtoReg,
    output logic                    RegWrite,
    output logic                    MemWrite,
    output logic                    MemRead,
    output logic                    ALUSrcA,
    output logic                    Jump,
    output logic                    JALR,
    output logic                    SB_type,
    output logic [3:0]              ALUCode,
    output logic [1:0]              ALUSrcB,
    output logic [2:0]              funct3,
    output logic [4:0]              rs1Addr,
    output logic [4:0]              rs2Addr,
    output logic [4:0]              rdAddr,
    output logic [XLEN-1:0]         Imm,
    output logic [XLEN-1:0]         offset,
    output logic                    illegal,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            mem_to_reg;
        logic            reg_write;
        logic            mem_write;
        logic            mem_read;
        logic            alu_src_a;
        logic            jump;
        logic            jalr;
        logic            sb_type;
        logic [3:0]      alu_code;
        logic [1:0]      alu_src_b;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] offset;
        logic            illegal;
    } dec_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // alt selects SUB/SRA; callers only raise it where instr[30] is meaningful
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic dec_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        dec_t        d;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_b;
        logic [31:0] imm_u;
        logic [31:0] imm_j;
        imm_i = {{20{instr[31]}}, instr[31:20]};
        imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u = {instr[31:12], 12'h000};
        imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        d        = '0;
        d.pc     = pc;
        d.funct3 = instr[14:12];
        d.rs1    = instr[19:15];
        d.rs2    = instr[24:20];
        d.rd     = instr[11:7];
        case (instr[6:0])
            OPC_LUI: begin
                d.reg_write = 1'b1;
                d.alu_code  = ALU_PASSB;
                d.alu_src_b = 2'd1;
                d.imm       = sext32(imm_u);
            end
            OPC_AUIPC: begin
                d.reg_write = 1'b1;
                d.alu_src_a = 1'b1;
                d.alu_src_b = 2'd1;
                d.imm       = sext32(imm_u);
            end
            OPC_JAL: begin
                d.jump      = 1'b1;
                d.reg_write = 1'b1;
                d.alu_src_a = 1'b1;
                d.alu_src_b = 2'd2;
                d.offset    = sext32(imm_j);
            end
            OPC_JALR: begin
                d.jump      = 1'b1;
                d.jalr      = 1'b1;
                d.reg_write = 1'b1;
                d.alu_src_a = 1'b1;
                d.alu_src_b = 2'd2;
                d.imm       = sext32(imm_i);
                d.offset    = sext32(imm_i);
            end
            OPC_BRANCH: begin
                d.sb_type = 1'b1;
                d.offset  = sext32(imm_b);
                case (instr[14:12])
                    3'b100, 3'b101: d.alu_code = ALU_SLT;
                    3'b110, 3'b111: d.alu_code = ALU_SLTU;
                    default:        d.alu_code = ALU_SUB;
                endcase
            end
            OPC_LOAD: begin
                d.mem_read   = 1'b1;
                d.mem_to_reg = 1'b1;
                d.reg_write  = 1'b1;
                d.alu_src_b  = 2'd1;
                d.imm        = sext32(imm_i);
            end
            OPC_STORE: begin
                d.mem_write = 1'b1;
                d.alu_src_b = 2'd1;
                d.imm       = sext32(imm_s);
            end
            OPC_OPIMM: begin
                d.reg_write = 1'b1;
                d.alu_src_b = 2'd1;
                d.imm       = sext32(imm_i);
                d.alu_code  = alu_from_f3(instr[14:12], (instr[14:12] == 3'b101) & instr[30]);
            end
            OPC_OP: begin
                d.reg_write = 1'b1;
                d.alu_code  = alu_from_f3(instr[14:12], instr[30]);
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    logic [31:0]     instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            out_valid_q, out_valid_d;
    dec_t            dec_q, dec_d, dec_s;
    logic            push_s, load_out_s, buf_empty_s, bypass_s, pop_s, buf_wr_s;
    logic [31:0]     sel_instr_s;
    logic [XLEN-1:0] sel_pc_s;

    assign in_ready = (count_q < CW'(DEPTH));

    // Handshake qualification and decode of whichever instruction feeds the output stage
    always_comb begin
        push_s      = in_valid & in_ready;
        load_out_s  = ~out_valid_q | out_ready;
        buf_empty_s = (count_q == '0);
        bypass_s    = load_out_s & buf_empty_s & push_s;
        pop_s       = load_out_s & ~buf_empty_s;
        buf_wr_s    = push_s & ~bypass_s & ~flush;
        sel_instr_s = buf_empty_s ? in_instr : instr_mem_q[rd_ptr_q];
        sel_pc_s    = buf_empty_s ? in_pc : pc_mem_q[rd_ptr_q];
        dec_s       = decode(sel_instr_s, sel_pc_s);
    end

    // Next-state for pointers, occupancy and the output register; flush overrides transfers
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        dec_d       = dec_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (buf_wr_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(buf_wr_s) - CW'(pop_s);
            if (load_out_s) begin
                out_valid_d = pop_s | bypass_s;
            end else begin
                out_valid_d = out_valid_q;
            end
            // fields only change on a real load, so they stay zero after reset until first use
            if (pop_s | bypass_s) begin
                dec_d = dec_s;
            end else begin
                dec_d = dec_q;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            dec_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            dec_q       <= dec_d;
        end
    end

    // Buffer storage; contents beyond count are never observed, so no reset is needed
    always_ff @(posedge clk) begin
        if (buf_wr_s && !reset) begin
            instr_mem_q[wr_ptr_q] <= in_instr;
            pc_mem_q[wr_ptr_q]    <= in_pc;
        end
    end

    assign out_valid = out_valid_q;
    assign count     = count_q;
    assign out_pc    = dec_q.pc;
    assign MemtoReg  = dec_q.mem_to_reg;
    assign RegWrite  = dec_q.reg_write;
    assign MemWrite  = dec_q.mem_write;
    assign MemRead   = dec_q.mem_read;
    assign ALUSrcA   = dec_q.alu_src_a;
    assign Jump      = dec_q.jump;
    assign JALR      = dec_q.jalr;
    assign SB_type   = dec_q.sb_type;
    assign ALUCode   = dec_q.alu_code;
    assign ALUSrcB   = dec_q.alu_src_b;
    assign funct3    = dec_q.funct3;
    assign rs1Addr   = dec_q.rs1;
    assign rs2Addr   = dec_q.rs2;
    assign rdAddr    = dec_q.rd;
    assign Imm       = dec_q.imm;
    assign offset    = dec_q.offset;
    assign illegal   = dec_q.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed vectors plus randomized traffic
// checked against a queue-based reference model and an independent decode table.
module tb_decode_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc, out_pc, Imm, offset;
    logic            MemtoReg, RegWrite, MemWrite, MemRead, ALUSrcA, Jump, JALR, SB_type, illegal;
    logic [3:0]      ALUCode;
    logic [1:0]      ALUSrcB;
    logic [2:0]      funct3;
    logic [4:0]      rs1Addr, rs2Addr, rdAddr;
    logic [CW-1:0]   count;

    always #5 clk = ~clk;

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .MemRead(MemRead), .ALUSrcA(ALUSrcA), .Jump(Jump), .JALR(JALR),
        .SB_type(SB_type), .ALUCode(ALUCode), .ALUSrcB(ALUSrcB), .funct3(funct3),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rdAddr(rdAddr), .Imm(Imm), .offset(offset),
        .illegal(illegal), .count(count)
    );

    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    typedef struct {
        bit mtr, rw, mw, mr, asa, jmp, jalr, sb, ill, imm_v, off_v;
        logic [3:0] alu; logic [1:0] asb; logic [31:0] imm, off;
    } exp_t;

    ent_t fifo[$];
    ent_t cur;
    bit   cur_v;
    int   n_checks = 0;
    int   n_errors = 0;
    int   alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t exp_decode(input logic [31:0] w);
        exp_t e;
        int   f3;
        int   ii, is, ib, ij;
        e  = '{default: '0};
        f3 = int'(w[14:12]);
        ii = int'($signed(w[31:20]));
        is = int'($signed({w[31:25], w[11:7]}));
        ib = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        ij = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        case (w[6:0])
            7'h37: begin e.rw = 1; e.alu = 4'd10; e.asb = 2'd1; e.imm = w & 32'hFFFFF000; e.imm_v = 1; end
            7'h17: begin e.rw = 1; e.asa = 1; e.asb = 2'd1; e.imm = w & 32'hFFFFF000; e.imm_v = 1; end
            7'h6f: begin e.rw = 1; e.jmp = 1; e.asa = 1; e.asb = 2'd2; e.off = ij; e.off_v = 1; end
            7'h67: begin
                e.rw = 1; e.jmp = 1; e.jalr = 1; e.asa = 1; e.asb = 2'd2;
                e.imm = ii; e.imm_v = 1; e.off = ii; e.off_v = 1;
            end
            7'h63: begin
                e.sb = 1; e.off = ib; e.off_v = 1;
                e.alu = (f3 < 4) ? 4'd1 : (f3 < 6) ? 4'd3 : 4'd4;
            end
            7'h03: begin e.mr = 1; e.mtr = 1; e.rw = 1; e.asb = 2'd1; e.imm = ii; e.imm_v = 1; end
            7'h23: begin e.mw = 1; e.asb = 2'd1; e.imm = is; e.imm_v = 1; end
            7'h13: begin
                e.rw = 1; e.asb = 2'd1; e.imm = ii; e.imm_v = 1;
                e.alu = (f3 == 5 && w[30]) ? 4'd7 : 4'(alu_tab[f3]);
            end
            7'h33: begin
                e.rw = 1;
                e.alu = (w[30] && f3 == 0) ? 4'd1 : (w[30] && f3 == 5) ? 4'd7 : 4'(alu_tab[f3]);
            end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    task automatic compare_all();
        exp_t e;
        check_eq("count", count, fifo.size());
        check_eq("in_ready", in_ready, fifo.size() < DEPTH);
        check_eq("out_valid", out_valid, cur_v);
        if (cur_v) begin
            e = exp_decode(cur.instr);
            check_eq("illegal", illegal, e.ill);
            check_eq("RegWrite", RegWrite, e.rw);
            check_eq("MemWrite", MemWrite, e.mw);
            check_eq("MemRead", MemRead, e.mr);
            check_eq("Jump", Jump, e.jmp);
            check_eq("SB_type", SB_type, e.sb);
            if (!e.ill) begin
                check_eq("out_pc", out_pc, cur.pc);
                check_eq("MemtoReg", MemtoReg, e.mtr);
                check_eq("ALUSrcA", ALUSrcA, e.asa);
                check_eq("JALR", JALR, e.jalr);
                check_eq("ALUCode", ALUCode, e.alu);
                check_eq("ALUSrcB", ALUSrcB, e.asb);
                check_eq("funct3", funct3, cur.instr[14:12]);
                check_eq("rs1Addr", rs1Addr, cur.instr[19:15]);
                check_eq("rs2Addr", rs2Addr, cur.instr[24:20]);
                check_eq("rdAddr", rdAddr, cur.instr[11:7]);
                if (e.imm_v) check_eq("Imm", Imm, e.imm);
                if (e.off_v) check_eq("offset", offset, e.off);
            end
        end
    endtask

    // One clock: apply inputs, advance the reference model, then compare after the edge
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input bit ordy, input bit fl);
        bit acc;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        acc = v && (fifo.size() < DEPTH);
        if (fl) begin
            fifo.delete();
            cur_v = 0;
        end else begin
            if (acc) fifo.push_back('{ins, pc});
            if (!cur_v || ordy) begin
                if (fifo.size() > 0) begin
                    cur   = fifo.pop_front();
                    cur_v = 1;
                end else begin
                    cur_v = 0;
                end
            end
        end
        @(posedge clk); #1;
        compare_all();
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_ctrl"}, {MemtoReg, RegWrite, MemWrite, MemRead, ALUSrcA, Jump, JALR,
                                   SB_type, ALUCode, ALUSrcB, illegal}, 64'd0);
        check_eq({tag, "_pc"}, out_pc, 64'd0);
        check_eq({tag, "_imm"}, Imm, 64'd0);
        check_eq({tag, "_off"}, offset, 64'd0);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [6:0]  op;
        logic [2:0]  f3;
        r  = $urandom;
        f3 = r[14:12];
        case ($urandom_range(0, 9))
            0: return {r[31:7], 7'h37};
            1: return {r[31:7], 7'h17};
            2: return {r[31:7], 7'h6f};
            3: return {r[31:15], 3'b000, r[11:7], 7'h67};
            4: begin
                if (f3 == 3'b010 || f3 == 3'b011) f3 = 3'b000;
                return {r[31:15], f3, r[11:7], 7'h63};
            end
            5: return {r[31:7], 7'h03};
            6: return {r[31:7], 7'h23};
            7: begin
                if (f3 == 3'b001) r[31:25] = 7'h00;
                if (f3 == 3'b101) r[31:25] = r[0] ? 7'h20 : 7'h00;
                return {r[31:15], f3, r[11:7], 7'h13};
            end
            8: begin
                r[31:25] = ((f3 == 3'b000 || f3 == 3'b101) && r[0]) ? 7'h20 : 7'h00;
                return {r[31:15], f3, r[11:7], 7'h33};
            end
            default: begin
                do op = 7'($urandom);
                while (op inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33});
                return {r[31:7], op};
            end
        endcase
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; flush = 1'b0; out_ready = 1'b0;
        fifo.delete(); cur_v = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rst_count", count, 64'd0);
        check_eq("rst_out_valid", out_valid, 64'd0);
        check_zero_outputs("rst");
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_in_ready", in_ready, 64'd1);
        check_eq("post_rst_count", count, 64'd0);
        check_zero_outputs("post_rst");

        // Directed decode vectors
        cycle(1, 32'h00003f37, 32'h00000100, 1, 0);
        check_eq("lui_valid", out_valid, 64'd1);
        check_eq("lui_rd", rdAddr, 64'd30);
        check_eq("lui_imm", Imm, 64'h00003000);
        check_eq("lui_rw", RegWrite, 64'd1);
        check_eq("lui_alu", ALUCode, 64'd10);
        check_eq("lui_asb", ALUSrcB, 64'd1);
        cycle(1, 32'hfc000ae3, 32'h00000104, 1, 0);
        check_eq("br_sb", SB_type, 64'd1);
        check_eq("br_rs1", rs1Addr, 64'd0);
        check_eq("br_rs2", rs2Addr, 64'd0);
        check_eq("br_off", offset, 64'hFFFFFFD4);
        check_eq("br_alu", ALUCode, 64'd1);
        check_eq("br_rw", RegWrite, 64'd0);
        cycle(1, 32'h001c2623, 32'h00000108, 1, 0);
        check_eq("sw_mw", MemWrite, 64'd1);
        check_eq("sw_rs1", rs1Addr, 64'd24);
        check_eq("sw_rs2", rs2Addr, 64'd1);
        check_eq("sw_imm", Imm, 64'hC);
        check_eq("sw_f3", funct3, 64'd2);
        cycle(1, 32'h02000fe7, 32'h0000010C, 1, 0);
        check_eq("jalr_jump", Jump, 64'd1);
        check_eq("jalr_jalr", JALR, 64'd1);
        check_eq("jalr_rd", rdAddr, 64'd31);
        check_eq("jalr_off", offset, 64'h20);
        cycle(1, 32'h0000007f, 32'h00000110, 1, 0);
        check_eq("ill_flag", illegal, 64'd1);
        check_eq("ill_en", {RegWrite, MemWrite, MemRead, Jump, SB_type}, 64'd0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Fill past capacity with the consumer stalled, then drain in order
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(1, 32'h00000013 | (32'(i + 1) << 7), 32'h00001000 + 32'(4 * i), 0, 0);
        check_eq("full_in_ready", in_ready, 64'd0);
        check_eq("full_count", count, DEPTH);
        check_eq("full_hold_pc", out_pc, 64'h00001000);
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 32'h0, 32'h0, 1, 0);

        // Sustained one-per-cycle throughput
        for (int i = 0; i < 10; i++) cycle(1, gen_instr(), 32'h00002000 + 32'(4 * i), 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Flush with three buffered entries and a concurrent push
        for (int i = 0; i < 4; i++) cycle(1, gen_instr(), 32'h00003000 + 32'(4 * i), 0, 0);
        check_eq("pre_flush_count", count, 64'd3);
        cycle(1, 32'h00100093, 32'h0000DEAC, 0, 1);
        check_eq("flush_valid", out_valid, 64'd0);
        check_eq("flush_count", count, 64'd0);
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 32'h0, 1, 0);

        // Reset in the middle of traffic
        for (int i = 0; i < 3; i++) cycle(1, gen_instr(), 32'h00004000 + 32'(4 * i), 0, 0);
        reset = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        fifo.delete(); cur_v = 0;
        check_eq("midrst_count", count, 64'd0);
        check_eq("midrst_valid", out_valid, 64'd0);
        check_eq("midrst_in_ready", in_ready, 64'd1);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 3) != 0, gen_instr(), {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
                  $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
